// File: rtl/interval_timer_ctrl.sv
// Interval timer sequencer: prescaled ticks drive an up-counter that reloads or stops at all-ones,
// raising a one-cycle tc_pulse and a sticky irq on each expiry.
module interval_timer_ctrl #(
    parameter int WID  = 16,
    parameter int PWID = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    input  logic            autorld,
    input  logic            gate,
    input  logic [PWID-1:0] prescale,
    input  logic [WID-1:0]  reload,
    input  logic            irq_ack,
    output logic [WID-1:0]  q,
    output logic            busy,
    output logic            tc_pulse,
    output logic            irq
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [WID-1:0]  q_q, q_d;
    logic [PWID-1:0] psc_q, psc_d;
    logic            tc_q, tc_d;
    logic            irq_q, irq_d;
    logic            tick;
    logic            expiry;

    // A restart or stop on this edge pre-empts counting, so no tick can happen then.
    always_comb begin
        tick   = (state_q == RUN) && gate && !stop && !start && (psc_q == prescale);
        expiry = tick && (q_q == {WID{1'b1}});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            psc_q   <= '0;
            tc_q    <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            psc_q   <= psc_d;
            tc_q    <= tc_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = IDLE;
        end else if (start) begin
            state_d = LOAD;
        end else begin
            case (state_q)
                LOAD:    state_d = RUN;
                RUN:     if (expiry && !autorld) state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        q_d   = q_q;
        psc_d = psc_q;
        if (!stop && state_q == LOAD) begin
            q_d   = reload;
            psc_d = '0;
        end else if (!stop && !start && state_q == RUN && gate) begin
            if (tick) begin
                psc_d = '0;
                if (expiry) q_d = autorld ? reload : q_q;
                else        q_d = q_q + 1'b1;
            end else begin
                psc_d = psc_q + 1'b1;
            end
        end
        tc_d  = expiry;
        irq_d = expiry | (irq_q & ~irq_ack);
    end

    always_comb begin
        busy     = (state_q == LOAD) || (state_q == RUN);
        q        = q_q;
        tc_pulse = tc_q;
        irq      = irq_q;
    end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed bench for interval_timer_ctrl at WID=8; expected values are hand-derived cycle by cycle.
module tb_interval_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, stop = 1'b0, autorld = 1'b0, gate = 1'b1, irq_ack = 1'b0;
    logic [7:0] prescale = 8'd0;
    logic [7:0] reload = 8'd0;
    logic [7:0] q;
    logic       busy, tc_pulse, irq;

    int passed = 0;
    int total  = 0;

    interval_timer_ctrl #(.WID(8), .PWID(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .autorld(autorld),
        .gate(gate), .prescale(prescale), .reload(reload), .irq_ack(irq_ack),
        .q(q), .busy(busy), .tc_pulse(tc_pulse), .irq(irq)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; irq_ack = 1'b0; gate = 1'b1;
        #3;
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        total++;
        if ({q, busy, tc_pulse, irq} !== 11'h0)
            $display("FAIL reset_init: got q=%h busy=%b tc=%b irq=%b, want all 0", q, busy, tc_pulse, irq);
        else passed++;
        do_reset();
        reload = 8'h3F; prescale = 8'd0; autorld = 1'b1; gate = 1'b1;
        start = 1'b1; step(); start = 1'b0;   // edge0: LOAD
        step();                               // edge1: q=3F
        step();                               // edge2: q=40
        total++;
        if (q !== 8'h40 || busy !== 1'b1) $display("FAIL reset_pre: got q=%h busy=%b, want 40 1", q, busy);
        else passed++;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({q, busy, tc_pulse, irq} !== 11'h0)
            $display("FAIL reset_async: got q=%h busy=%b tc=%b irq=%b, want all 0", q, busy, tc_pulse, irq);
        else passed++;
        #1 rst = 1'b0;
        step();
        total++;
        if (busy !== 1'b0 || q !== 8'h00) $display("FAIL reset_idle: got busy=%b q=%h, want 0 00", busy, q);
        else passed++;
    endtask

    task automatic test_oneshot();
        logic [7:0] exp_q [1:5];
        logic       exp_tc[1:5];
        logic       exp_b [1:5];
        logic       exp_i [1:5];
        exp_q = '{8'hFD, 8'hFE, 8'hFF, 8'hFF, 8'hFF};
        exp_tc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_b = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_i = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        reload = 8'hFD; prescale = 8'd0; autorld = 1'b0; gate = 1'b1;
        start = 1'b1; step(); start = 1'b0;   // edge0
        total++;
        if (busy !== 1'b1 || q !== 8'h00) $display("FAIL oneshot_load: got busy=%b q=%h, want 1 00", busy, q);
        else passed++;
        for (int e = 1; e <= 5; e++) begin
            step();
            total++;
            if (q !== exp_q[e] || tc_pulse !== exp_tc[e] || busy !== exp_b[e] || irq !== exp_i[e])
                $display("FAIL oneshot_e%0d: got q=%h tc=%b busy=%b irq=%b, want q=%h tc=%b busy=%b irq=%b",
                         e, q, tc_pulse, busy, irq, exp_q[e], exp_tc[e], exp_b[e], exp_i[e]);
            else passed++;
        end
    endtask

    // reload FE, prescale 2: q is FE for 3 cycles, FF for 3, expiring every 6 enabled cycles.
    task automatic test_periodic();
        int         n;
        logic [7:0] eq;
        logic       etc;
        do_reset();
        reload = 8'hFE; prescale = 8'd2; autorld = 1'b1; gate = 1'b1;
        start = 1'b1; step(); start = 1'b0;   // edge0
        step();                               // edge1: q=FE
        total++;
        if (q !== 8'hFE) $display("FAIL periodic_load: got q=%h want FE", q);
        else passed++;
        for (int e = 2; e <= 25; e++) begin
            step();
            n   = e - 1;
            eq  = ((n / 3) % 2 == 0) ? 8'hFE : 8'hFF;
            etc = (n % 6 == 0);
            total++;
            if (q !== eq || tc_pulse !== etc || busy !== 1'b1)
                $display("FAIL periodic_e%0d: got q=%h tc=%b busy=%b, want q=%h tc=%b busy=1", e, q, tc_pulse, busy, eq, etc);
            else passed++;
        end
    endtask

    // Gate low over edges 6..10 freezes everything; expiries move from edges 7,13 to 12,18.
    task automatic test_gate();
        int         n;
        logic [7:0] eq;
        logic       etc;
        do_reset();
        reload = 8'hFE; prescale = 8'd2; autorld = 1'b1; gate = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        step();
        n = 0;
        for (int e = 2; e <= 20; e++) begin
            gate = !(e >= 6 && e <= 10);
            step();
            if (gate) n++;
            eq  = ((n / 3) % 2 == 0) ? 8'hFE : 8'hFF;
            etc = gate && (n % 6 == 0);
            total++;
            if (q !== eq || tc_pulse !== etc)
                $display("FAIL gate_e%0d: got q=%h tc=%b, want q=%h tc=%b", e, q, tc_pulse, eq, etc);
            else passed++;
        end
        gate = 1'b1;
        total++;
        if (irq !== 1'b1) $display("FAIL gate_irq: got irq=%b want 1", irq);
        else passed++;
    endtask

    task automatic test_priority();
        do_reset();
        reload = 8'h10; prescale = 8'd0; autorld = 1'b1; gate = 1'b1;
        start = 1'b1; step(); start = 1'b0;   // edge0 LOAD
        step(); step(); step();               // q=10,11,12
        stop = 1'b1; start = 1'b1; step(); stop = 1'b0; start = 1'b0;
        total++;
        if (busy !== 1'b0 || q !== 8'h12) $display("FAIL prio_stop_start: got busy=%b q=%h, want 0 12", busy, q);
        else passed++;
        step();
        total++;
        if (busy !== 1'b0 || q !== 8'h12) $display("FAIL prio_idle_hold: got busy=%b q=%h, want 0 12", busy, q);
        else passed++;
        start = 1'b1; step(); start = 1'b0;   // LOAD
        step(); step();                       // q=10,11
        total++;
        if (q !== 8'h11) $display("FAIL prio_rerun: got q=%h want 11", q);
        else passed++;
        reload = 8'h20;
        start = 1'b1; step(); start = 1'b0;
        total++;
        if (busy !== 1'b1 || q !== 8'h11) $display("FAIL prio_restart_edge: got busy=%b q=%h, want 1 11", busy, q);
        else passed++;
        step();
        total++;
        if (q !== 8'h20) $display("FAIL prio_restart_load: got q=%h want 20", q);
        else passed++;
    endtask

    task automatic test_irq_ack();
        do_reset();
        reload = 8'hFE; prescale = 8'd0; autorld = 1'b0; gate = 1'b1;
        start = 1'b1; step(); start = 1'b0;   // edge0
        step();                               // edge1 q=FE
        irq_ack = 1'b1;
        step();                               // edge2 q=FF
        step();                               // edge3 expiry with ack held
        total++;
        if (irq !== 1'b1 || tc_pulse !== 1'b1 || q !== 8'hFF)
            $display("FAIL ack_coincide: got irq=%b tc=%b q=%h, want 1 1 FF", irq, tc_pulse, q);
        else passed++;
        step();                               // edge4 ack alone
        irq_ack = 1'b0;
        total++;
        if (irq !== 1'b0 || tc_pulse !== 1'b0 || busy !== 1'b0)
            $display("FAIL ack_clear: got irq=%b tc=%b busy=%b, want 0 0 0", irq, tc_pulse, busy);
        else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        reload = 8'hFF; prescale = 8'd0; autorld = 1'b1; gate = 1'b1;
        start = 1'b1; step(); start = 1'b0;   // edge0
        step();                               // edge1 q=FF, no expiry yet
        total++;
        if (q !== 8'hFF || tc_pulse !== 1'b0) $display("FAIL b2b_first: got q=%h tc=%b, want FF 0", q, tc_pulse);
        else passed++;
        for (int e = 2; e <= 8; e++) begin
            step();
            total++;
            if (q !== 8'hFF || tc_pulse !== 1'b1 || irq !== 1'b1 || busy !== 1'b1)
                $display("FAIL b2b_e%0d: got q=%h tc=%b irq=%b busy=%b, want FF 1 1 1", e, q, tc_pulse, irq, busy);
            else passed++;
        end
        stop = 1'b1; step(); stop = 1'b0;
        step();
        total++;
        if (tc_pulse !== 1'b0 || busy !== 1'b0 || irq !== 1'b1)
            $display("FAIL b2b_stop: got tc=%b busy=%b irq=%b, want 0 0 1", tc_pulse, busy, irq);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_gate();
        test_priority();
        test_irq_ack();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
